decode_issue: RTL and testbench
===============================

DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 Parameter FWD_EN, default 1: when 1, writeback data is bypassed into same-cycle operand reads; when 0, the block stalls instead.
REQ-002 clk_i  in  1  sole clock, rising edge.
REQ-003 rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 instr_valid_i  in  1  fetch offers instr_i/pc_i.
REQ-005 instr_ready_o  out  1  block accepts the offered instruction this cycle.
REQ-006 instr_i  in  32  RV32 instruction word.
REQ-007 pc_i  in  32  address of instr_i.
REQ-008 ex_valid_o  out  1  issued ALU operation valid.
REQ-009 ex_ready_i  in  1  execute stage consumes the operation.
REQ-010 a_o, b_o  out  32 each  ALU operands.
REQ-011 funct3_o  out  3  ALU function select.
REQ-012 funct7_o  out  1  ALU modifier: 1 = add/srl, 0 = sub/sra.
REQ-013 pc_add_o  out  1  forces an ALU add (AUIPC).
REQ-014 rd_o  out  5  destination register of the issued operation.
REQ-015 wb_valid_i, wb_rd_i[5], wb_data_i[32]  in  writeback of a completed result.
REQ-016 illegal_o  out  1  one-cycle pulse: an unsupported opcode was accepted.

Function
REQ-017 The block SHALL accept an instruction when instr_valid_i and instr_ready_o are both high, and SHALL present it on ex_* on the next clock edge (latency 1).
REQ-018 instr_ready_o SHALL be (!ex_valid_o || ex_ready_i) && !hazard; ex_* SHALL remain stable while ex_valid_o && !ex_ready_i.
REQ-019 Supported opcodes are OP (0110011), OP-IMM (0010011), LUI (0110111) and AUIPC (0010111); any other opcode SHALL be consumed, SHALL pulse illegal_o on the next cycle, and SHALL NOT raise ex_valid_o.
REQ-020 OP: a_o=rs1, b_o=rs2, funct3_o=instr[14:12], funct7_o=~instr[30].
REQ-021 OP-IMM: a_o=rs1, b_o=sign-extended instr[31:20], funct7_o=1, except funct3 001/101, where b_o={27'b0,instr[24:20]} and funct7_o=~instr[30].
REQ-022 OP shifts (funct3 001/101) SHALL mask b_o to rs2[4:0], zero-extended.
REQ-023 LUI: a_o=0, b_o={instr[31:12],12'b0}, funct3_o=000, funct7_o=1, pc_add_o=0.
REQ-024 AUIPC: a_o=pc_i, b_o={instr[31:12],12'b0}, pc_add_o=1.
REQ-025 Register x0 SHALL read as 0; writebacks to x0 SHALL be ignored.
REQ-026 A 32-bit pending mask SHALL set bit rd when an instruction with rd!=0 issues, and SHALL clear bit wb_rd_i when wb_valid_i is high; on a simultaneous set and clear of the same bit, the set wins.
REQ-027 hazard SHALL be high when a used source (rs1 for all except LUI/AUIPC; rs2 for OP only) is pending, unless FWD_EN=1 and wb_valid_i writes that register this cycle, in which case wb_data_i is used.
REQ-028 Writeback SHALL update the register file at the clock edge regardless of stall state.

Reset
REQ-029 While rst_ni is low: ex_valid_o=0, illegal_o=0, a_o=b_o=0, funct3_o=0, funct7_o=0, pc_add_o=0, rd_o=0, pending mask=0, and all registers=0.
REQ-030 Reset asserted mid-operation SHALL discard any held operation; the first accept is allowed on the first edge after rst_ni rises.

Structure
REQ-031 Opcode constants, the ALU funct3 encodings and the immediate-format typedef SHALL live in a shared package that the ALU also uses.
REQ-032 The register file SHALL be a sub-module, regfile (2 read ports, 1 write port, x0 hardwired to 0); decode, the scoreboard and the output register stay in decode_issue.

Verification
REQ-033 Preload x1=5, x2=3; issue add x3,x1,x2 (0x002081B3) -> next cycle ex_valid_o=1, a_o=5, b_o=3, funct3_o=000, funct7_o=1, rd_o=3.
REQ-034 Issue addi x4,x0,-1 then srai x5,x4,4 with wb x4=0xFFFFFFFF on the cycle the srai is offered -> srai issues the same cycle (FWD_EN=1) with a_o=0xFFFFFFFF, b_o=4, funct7_o=0.
REQ-035 Hold ex_ready_i=0 for 3 cycles with a second instruction offered -> instr_ready_o=0 throughout and ex_* unchanged; ex_ready_i=1 -> the second instruction issues on the next edge.
REQ-036 auipc x6,0x12345 at pc 0x100 -> a_o=0x100, b_o=0x12345000, pc_add_o=1; lui x7,0xABCDE -> a_o=0, b_o=0xABCDE000.
REQ-037 Opcode 0x7F -> illegal_o=1 for exactly one cycle, ex_valid_o stays 0, pending mask unchanged.
REQ-038 Drop rst_ni while ex_valid_o=1 and x1 pending -> ex_valid_o=0 and mask=0 immediately; after release, add x3,x1,x2 issues without stalling.

Source files
------------

// File: rtl/decode_issue_pkg.sv
// Shared decode definitions for the decode/issue stage and the ALU: opcodes,
// ALU function encodings, immediate formats and the issued-operation record.
package decode_issue_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [1:0] {
        IMM_NONE  = 2'd0,
        IMM_I     = 2'd1,
        IMM_SHAMT = 2'd2,
        IMM_U     = 2'd3
    } imm_fmt_e;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  funct3;
        logic        funct7;
        logic        pc_add;
        logic [4:0]  rd;
    } ex_op_t;

    function automatic logic is_shift(input logic [2:0] funct3);
        return (funct3 == F3_SLL) || (funct3 == F3_SR);
    endfunction

    function automatic logic [31:0] gen_imm(input imm_fmt_e fmt, input logic [31:0] instr);
        logic [31:0] imm;
        case (fmt)
            IMM_I:     imm = {{20{instr[31]}}, instr[31:20]};
            IMM_SHAMT: imm = {27'd0, instr[24:20]};
            IMM_U:     imm = {instr[31:12], 12'd0};
            default:   imm = 32'd0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_issue_regfile.sv
// 32x32 register file: two asynchronous read ports, one write port, x0 reads 0.
module regfile (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [4:0]  ra1_i,
    output logic [31:0] rd1_o,
    input  logic [4:0]  ra2_i,
    output logic [31:0] rd2_o,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i
);

    logic [31:0] regs_q [0:31];

    assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : regs_q[ra1_i];
    assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : regs_q[ra2_i];

    // Register storage; writes to x0 are dropped so it stays zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (we_i && (wa_i != 5'd0)) begin
            regs_q[wa_i] <= wd_i;
        end else begin
            regs_q[0] <= 32'd0;
        end
    end

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: decodes RV32 ALU instructions, tracks pending
// destinations, optionally bypasses writeback data and registers the ALU operation.
module decode_issue
    import decode_issue_pkg::*;
#(
    parameter bit FWD_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic        ex_valid_o,
    input  logic        ex_ready_i,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [2:0]  funct3_o,
    output logic        funct7_o,
    output logic        pc_add_o,
    output logic [4:0]  rd_o,
    input  logic        wb_valid_i,
    input  logic [4:0]  wb_rd_i,
    input  logic [31:0] wb_data_i,
    output logic        illegal_o
);

    logic [6:0]  opcode_s;
    logic [4:0]  rd_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [2:0]  funct3_s;
    logic [31:0] rf_rd1_s;
    logic [31:0] rf_rd2_s;
    logic [31:0] rs1_val_s;
    logic [31:0] rs2_val_s;
    logic        fwd1_s;
    logic        fwd2_s;
    logic        use_rs1_s;
    logic        use_rs2_s;
    logic        legal_s;
    logic        hazard_s;
    logic        accept_s;
    imm_fmt_e    imm_fmt_s;
    ex_op_t      op_s;

    ex_op_t      op_d, op_q;
    logic        ex_valid_d, ex_valid_q;
    logic        illegal_d, illegal_q;
    logic [31:0] pend_d, pend_q;

    assign opcode_s = instr_i[6:0];
    assign rd_s     = instr_i[11:7];
    assign funct3_s = instr_i[14:12];
    assign rs1_s    = instr_i[19:15];
    assign rs2_s    = instr_i[24:20];

    regfile u_regfile (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .ra1_i (rs1_s),
        .rd1_o (rf_rd1_s),
        .ra2_i (rs2_s),
        .rd2_o (rf_rd2_s),
        .we_i  (wb_valid_i),
        .wa_i  (wb_rd_i),
        .wd_i  (wb_data_i)
    );

    // Opcode classification: legality, used sources and immediate format.
    always_comb begin
        legal_s   = 1'b0;
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b0;
        imm_fmt_s = IMM_NONE;
        case (opcode_s)
            OPC_OP: begin
                legal_s   = 1'b1;
                use_rs2_s = 1'b1;
            end
            OPC_OP_IMM: begin
                legal_s   = 1'b1;
                imm_fmt_s = is_shift(funct3_s) ? IMM_SHAMT : IMM_I;
            end
            OPC_LUI, OPC_AUIPC: begin
                legal_s   = 1'b1;
                use_rs1_s = 1'b0;
                imm_fmt_s = IMM_U;
            end
            default: begin
                legal_s = 1'b0;
            end
        endcase
    end

    // A same-cycle writeback to a source overrides both the stale register and its pending bit.
    assign fwd1_s = FWD_EN && wb_valid_i && (wb_rd_i == rs1_s) && (rs1_s != 5'd0);
    assign fwd2_s = FWD_EN && wb_valid_i && (wb_rd_i == rs2_s) && (rs2_s != 5'd0);

    assign rs1_val_s = fwd1_s ? wb_data_i : rf_rd1_s;
    assign rs2_val_s = fwd2_s ? wb_data_i : rf_rd2_s;

    assign hazard_s = (use_rs1_s && pend_q[rs1_s] && !fwd1_s) ||
                      (use_rs2_s && pend_q[rs2_s] && !fwd2_s);

    assign instr_ready_o = (!ex_valid_q || ex_ready_i) && !hazard_s;
    assign accept_s      = instr_valid_i && instr_ready_o;

    // Operand and ALU-control formation for the offered instruction.
    always_comb begin
        op_s.a      = rs1_val_s;
        op_s.b      = gen_imm(imm_fmt_s, instr_i);
        op_s.funct3 = funct3_s;
        op_s.funct7 = 1'b1;
        op_s.pc_add = 1'b0;
        op_s.rd     = rd_s;
        case (opcode_s)
            OPC_OP: begin
                op_s.b      = is_shift(funct3_s) ? {27'd0, rs2_val_s[4:0]} : rs2_val_s;
                op_s.funct7 = ~instr_i[30];
            end
            OPC_OP_IMM: begin
                if (is_shift(funct3_s)) begin
                    op_s.funct7 = ~instr_i[30];
                end else begin
                    op_s.funct7 = 1'b1;
                end
            end
            OPC_LUI: begin
                op_s.a      = 32'd0;
                op_s.funct3 = F3_ADD;
            end
            OPC_AUIPC: begin
                op_s.a      = pc_i;
                op_s.funct3 = F3_ADD;
                op_s.pc_add = 1'b1;
            end
            default: begin
                op_s.pc_add = 1'b0;
            end
        endcase
    end

    // Next state of the issue register, illegal pulse and pending mask (issue beats writeback).
    always_comb begin
        op_d       = op_q;
        ex_valid_d = ex_valid_q;
        illegal_d  = 1'b0;
        pend_d     = pend_q;
        if (wb_valid_i) begin
            pend_d[wb_rd_i] = 1'b0;
        end else begin
            pend_d = pend_q;
        end
        if (accept_s) begin
            if (legal_s) begin
                op_d         = op_s;
                ex_valid_d   = 1'b1;
                pend_d[rd_s] = 1'b1;
            end else begin
                ex_valid_d = 1'b0;
                illegal_d  = 1'b1;
            end
        end else if (ex_ready_i) begin
            ex_valid_d = 1'b0;
        end else begin
            ex_valid_d = ex_valid_q;
        end
        pend_d[0] = 1'b0;
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q       <= '0;
            ex_valid_q <= 1'b0;
            illegal_q  <= 1'b0;
            pend_q     <= 32'd0;
        end else begin
            op_q       <= op_d;
            ex_valid_q <= ex_valid_d;
            illegal_q  <= illegal_d;
            pend_q     <= pend_d;
        end
    end

    assign ex_valid_o = ex_valid_q;
    assign illegal_o  = illegal_q;
    assign a_o        = op_q.a;
    assign b_o        = op_q.b;
    assign funct3_o   = op_q.funct3;
    assign funct7_o   = op_q.funct7;
    assign pc_add_o   = op_q.pc_add;
    assign rd_o       = op_q.rd;

endmodule

// File: tb/tb_decode_issue.sv
// Self-checking bench for decode_issue: vector table plus hand-written
// sequences for forwarding, hazard stall, backpressure and mid-operation reset.
module tb_decode_issue;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic        ex_valid_o;
    logic        ex_ready_i;
    logic [31:0] a_o;
    logic [31:0] b_o;
    logic [2:0]  funct3_o;
    logic        funct7_o;
    logic        pc_add_o;
    logic [4:0]  rd_o;
    logic        wb_valid_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        illegal_o;

    always #5 clk = ~clk;

    decode_issue #(.FWD_EN(1'b1)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .instr_valid_i(instr_valid_i),
        .instr_ready_o(instr_ready_o),
        .instr_i      (instr_i),
        .pc_i         (pc_i),
        .ex_valid_o   (ex_valid_o),
        .ex_ready_i   (ex_ready_i),
        .a_o          (a_o),
        .b_o          (b_o),
        .funct3_o     (funct3_o),
        .funct7_o     (funct7_o),
        .pc_add_o     (pc_add_o),
        .rd_o         (rd_o),
        .wb_valid_i   (wb_valid_i),
        .wb_rd_i      (wb_rd_i),
        .wb_data_i    (wb_data_i),
        .illegal_o    (illegal_o)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f3;
        logic        f7;
        logic        pca;
        logic [4:0]  rd;
        logic        ill;
    } vec_t;

    vec_t q[$];
    vec_t tbl[12];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] f3, input logic f7, input logic pca,
                                input logic [4:0] rd, input logic ill);
        vec_t v;
        v.instr = instr; v.pc = pc; v.a = a; v.b = b; v.f3 = f3;
        v.f7 = f7; v.pca = pca; v.rd = rd; v.ill = ill;
        return v;
    endfunction

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    // Scoreboard: compare every consumed operation or illegal pulse with the oldest expectation.
    always @(negedge clk) begin
        if (rst_ni && (illegal_o || (ex_valid_o && ex_ready_i))) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: output ex_valid=%b illegal=%b with nothing expected",
                         ex_valid_o, illegal_o);
            end else begin
                vec_t e;
                e = q.pop_front();
                if (e.ill) begin
                    chk("illegal_o", {31'd0, illegal_o}, 32'd1);
                    chk("illegal_no_ex", {31'd0, ex_valid_o}, 32'd0);
                end else begin
                    chk("ex_valid_o", {31'd0, ex_valid_o}, 32'd1);
                    chk("illegal_quiet", {31'd0, illegal_o}, 32'd0);
                    chk("a_o", a_o, e.a);
                    chk("b_o", b_o, e.b);
                    chk("funct3_o", {29'd0, funct3_o}, {29'd0, e.f3});
                    chk("funct7_o", {31'd0, funct7_o}, {31'd0, e.f7});
                    chk("pc_add_o", {31'd0, pc_add_o}, {31'd0, e.pca});
                    chk("rd_o", {27'd0, rd_o}, {27'd0, e.rd});
                end
            end
        end
    end

    // Offer one instruction (caller sits at a falling edge); push its expectation on accept.
    task automatic offer(input vec_t v, input bit immediate, input string name);
        instr_i       = v.instr;
        pc_i          = v.pc;
        instr_valid_i = 1'b1;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (immediate && n == 0) begin
                chk({name, "_ready"}, {31'd0, instr_ready_o}, 32'd1);
            end
            if (instr_ready_o) begin
                q.push_back(v);
                @(posedge clk);
                #1;
                instr_valid_i = 1'b0;
                return;
            end
            @(negedge clk);
        end
        tests++;
        fails++;
        $display("FAIL %s_timeout: instr_ready_o stayed 0 for 20 cycles", name);
        instr_valid_i = 1'b0;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] data);
        @(negedge clk);
        wb_valid_i = 1'b1;
        wb_rd_i    = rd;
        wb_data_i  = data;
        @(posedge clk);
        #1;
        wb_valid_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0; instr_valid_i = 1'b0; instr_i = 32'd0; pc_i = 32'd0;
        ex_ready_i = 1'b1; wb_valid_i = 1'b0; wb_rd_i = 5'd0; wb_data_i = 32'd0;

        tbl[0]  = mk(32'h002081B3, 32'h200, 32'd5, 32'd3, 3'd0, 1'b1, 1'b0, 5'd3, 1'b0);
        tbl[1]  = mk(r_type(7'h20, 5'd2, 5'd1, 3'd0, 5'd9), 32'h204, 32'd5, 32'd3, 3'd0, 1'b0, 1'b0, 5'd9, 1'b0);
        tbl[2]  = mk(r_type(7'h20, 5'd11, 5'd1, 3'd5, 5'd10), 32'h208, 32'd5, 32'd5, 3'd5, 1'b0, 1'b0, 5'd10, 1'b0);
        tbl[3]  = mk(r_type(7'h00, 5'd11, 5'd11, 3'd1, 5'd12), 32'h20C, 32'h25, 32'd5, 3'd1, 1'b1, 1'b0, 5'd12, 1'b0);
        tbl[4]  = mk(i_type(12'hFFE, 5'd1, 3'd4, 5'd13), 32'h210, 32'd5, 32'hFFFFFFFE, 3'd4, 1'b1, 1'b0, 5'd13, 1'b0);
        tbl[5]  = mk(i_type(12'h01F, 5'd1, 3'd1, 5'd14), 32'h214, 32'd5, 32'd31, 3'd1, 1'b1, 1'b0, 5'd14, 1'b0);
        tbl[6]  = mk(i_type(12'h404, 5'd11, 3'd5, 5'd15), 32'h218, 32'h25, 32'd4, 3'd5, 1'b0, 1'b0, 5'd15, 1'b0);
        tbl[7]  = mk(i_type(12'h007, 5'd0, 3'd0, 5'd16), 32'h21C, 32'd0, 32'd7, 3'd0, 1'b1, 1'b0, 5'd16, 1'b0);
        tbl[8]  = mk({20'h12345, 5'd6, 7'b0010111}, 32'h100, 32'h100, 32'h12345000, 3'd0, 1'b1, 1'b1, 5'd6, 1'b0);
        tbl[9]  = mk({20'hABCDE, 5'd7, 7'b0110111}, 32'h224, 32'd0, 32'hABCDE000, 3'd0, 1'b1, 1'b0, 5'd7, 1'b0);
        tbl[10] = mk(32'h000008FF, 32'h228, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b1);
        tbl[11] = mk(i_type(12'h001, 5'd17, 3'd0, 5'd18), 32'h22C, 32'd0, 32'd1, 3'd0, 1'b1, 1'b0, 5'd18, 1'b0);

        #1;
        chk("rst_ex_valid", {31'd0, ex_valid_o}, 32'd0);
        chk("rst_illegal", {31'd0, illegal_o}, 32'd0);
        chk("rst_a", a_o, 32'd0);
        chk("rst_b", b_o, 32'd0);
        chk("rst_ctl", {23'd0, funct3_o, funct7_o, pc_add_o, rd_o}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;

        wb(5'd1, 32'd5);
        wb(5'd2, 32'd3);
        wb(5'd11, 32'h25);
        wb(5'd0, 32'd99);

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            offer(tbl[i], 1'b1, $sformatf("tbl%0d", i));
        end

        // Forwarding: srai reads x4 from the writeback in the same cycle it is offered.
        @(negedge clk);
        offer(mk(i_type(12'hFFF, 5'd0, 3'd0, 5'd4), 32'h300, 32'd0, 32'hFFFFFFFF, 3'd0, 1'b1, 1'b0, 5'd4, 1'b0), 1'b1, "addi_x4");
        @(negedge clk);
        wb_valid_i = 1'b1; wb_rd_i = 5'd4; wb_data_i = 32'hFFFFFFFF;
        offer(mk(i_type(12'h404, 5'd4, 3'd5, 5'd5), 32'h304, 32'hFFFFFFFF, 32'd4, 3'd5, 1'b0, 1'b0, 5'd5, 1'b0), 1'b1, "srai_fwd");
        wb_valid_i = 1'b0;

        // Hazard: x5 pending stalls addi x20 until its writeback arrives.
        @(negedge clk);
        instr_i = i_type(12'h001, 5'd5, 3'd0, 5'd20); pc_i = 32'h308; instr_valid_i = 1'b1;
        for (int n = 0; n < 3; n++) begin
            #1;
            chk("hazard_stall", {31'd0, instr_ready_o}, 32'd0);
            @(negedge clk);
        end
        wb_valid_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 32'd10;
        #1;
        chk("hazard_release", {31'd0, instr_ready_o}, 32'd1);
        q.push_back(mk(instr_i, pc_i, 32'd10, 32'd1, 3'd0, 1'b1, 1'b0, 5'd20, 1'b0));
        @(posedge clk);
        #1;
        instr_valid_i = 1'b0; wb_valid_i = 1'b0;
        @(negedge clk);
        offer(mk(i_type(12'h000, 5'd5, 3'd0, 5'd21), 32'h30C, 32'd10, 32'd0, 3'd0, 1'b1, 1'b0, 5'd21, 1'b0), 1'b1, "x5_written");

        // Backpressure: held operation must not change while the next waits.
        @(posedge clk);
        #1;
        ex_ready_i = 1'b0;
        @(negedge clk);
        offer(mk(32'h002081B3, 32'h400, 32'd5, 32'd3, 3'd0, 1'b1, 1'b0, 5'd3, 1'b0), 1'b1, "bp_first");
        @(negedge clk);
        instr_i = {20'h00001, 5'd22, 7'b0110111}; pc_i = 32'h404; instr_valid_i = 1'b1;
        for (int n = 0; n < 3; n++) begin
            #1;
            chk("bp_ready", {31'd0, instr_ready_o}, 32'd0);
            chk("bp_valid", {31'd0, ex_valid_o}, 32'd1);
            chk("bp_a", a_o, 32'd5);
            chk("bp_b", b_o, 32'd3);
            chk("bp_rd", {27'd0, rd_o}, 32'd3);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        ex_ready_i = 1'b1;
        #1;
        chk("bp_resume_ready", {31'd0, instr_ready_o}, 32'd1);
        q.push_back(mk(instr_i, pc_i, 32'd0, 32'h00001000, 3'd0, 1'b1, 1'b0, 5'd22, 1'b0));
        @(posedge clk);
        #1;
        instr_valid_i = 1'b0;

        // Reset while an operation writing x1 is held.
        @(posedge clk);
        #1;
        ex_ready_i = 1'b0;
        @(negedge clk);
        offer(mk(32'h002080B3, 32'h500, 32'd5, 32'd3, 3'd0, 1'b1, 1'b0, 5'd1, 1'b0), 1'b1, "pre_reset");
        @(negedge clk);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_ex_valid", {31'd0, ex_valid_o}, 32'd0);
        chk("mid_rst_a", a_o, 32'd0);
        chk("mid_rst_rd", {27'd0, rd_o}, 32'd0);
        q.delete();
        ex_ready_i = 1'b1;
        @(negedge clk);
        #2;
        rst_ni = 1'b1;
        @(negedge clk);
        offer(mk(32'h002081B3, 32'h600, 32'd0, 32'd0, 3'd0, 1'b1, 1'b0, 5'd3, 1'b0), 1'b1, "post_reset");

        repeat (3) @(negedge clk);
        chk("sb_drained", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
